// File: rtl/byte_load_unit.sv
// byte_load_unit: single-outstanding byte/word load unit with merge ops and memory timeout.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, op, addr     load request (op: 0 LDW, 1 LDBZ, 2 LDBS, 3 LDBL, 4 LDBH)
//   dst_in              destination value used by merge ops and error results
//   mem_addr, mem_rd    word-aligned read request toward memory
//   mem_rdy, mem_rdata  read-data-valid strobe and little-endian read data
//   dst_out             registered load result
//   done, busy, err     completion pulse, activity flag, error flag (valid with done)
module byte_load_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] addr,
    input  logic [15:0] dst_in,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_rdy,
    input  logic [15:0] mem_rdata,
    output logic [15:0] dst_out,
    output logic        done,
    output logic        busy,
    output logic        err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [2:0]  op_q;
    logic [15:0] addr_q;
    logic [15:0] dst_q;
    logic [7:0]  b;
    logic [15:0] res;
    logic        bad_req;

    // Misaligned word loads and reserved ops complete immediately with an error.
    assign bad_req  = (op > 3'd4) || (op == 3'd0 && addr[0]);
    assign mem_rd   = state == REQ;
    assign mem_addr = mem_rd ? {addr_q[15:1], 1'b0} : 16'h0000;
    assign done     = state == DONE;
    assign busy     = state != IDLE;

    always_comb begin
        b   = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
        res = op_q == 3'd0 ? mem_rdata :
              op_q == 3'd1 ? {8'h00, b} :
              op_q == 3'd2 ? {{8{b[7]}}, b} :
              op_q == 3'd3 ? {dst_q[15:8], b} : {b, dst_q[7:0]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            dst_q   <= '0;
            dst_out <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        addr_q <= addr;
                        dst_q  <= dst_in;
                        cnt    <= '0;
                        if (bad_req) begin
                            dst_out <= dst_in;
                            err     <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    // Data arriving on the timeout edge still counts as success.
                    if (mem_rdy) begin
                        dst_out <= res;
                        err     <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == LAST) begin
                        dst_out <= dst_q;
                        err     <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
